// File: rtl/perf_pkg.sv
// Shared types, counter address map and commit classification helpers
// for the hardware performance-monitor counter bank.
package perf_pkg;

  // Functional unit of a committing instruction.
  typedef enum logic [2:0] {
    NONE      = 3'd0,
    LOAD      = 3'd1,
    STORE     = 3'd2,
    ALU       = 3'd3,
    CTRL_FLOW = 3'd4,
    MULT      = 3'd5,
    CSR       = 3'd6
  } fu_t;

  // Operation subset; only JAL/JALR matter for call/return classification.
  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    JAL  = 3'd2,
    JALR = 3'd3,
    LW   = 3'd4,
    SW   = 3'd5
  } op_t;

  typedef struct packed {
    fu_t        fu;
    op_t        op;
    logic [4:0] rs1;
    logic [4:0] rd;
  } commit_entry_t;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic valid;
    logic is_mispredict;
  } bp_resolve_t;

  // Counter addresses (low 5 bits of CSR 0xB03..0xB10).
  localparam logic [4:0] CNT_L1I_MISS   = 5'h03;
  localparam logic [4:0] CNT_L1D_MISS   = 5'h04;
  localparam logic [4:0] CNT_ITLB_MISS  = 5'h05;
  localparam logic [4:0] CNT_DTLB_MISS  = 5'h06;
  localparam logic [4:0] CNT_LOAD       = 5'h07;
  localparam logic [4:0] CNT_STORE      = 5'h08;
  localparam logic [4:0] CNT_EXCEPTION  = 5'h09;
  localparam logic [4:0] CNT_ERET       = 5'h0A;
  localparam logic [4:0] CNT_BRANCH     = 5'h0B;
  localparam logic [4:0] CNT_CALL       = 5'h0C;
  localparam logic [4:0] CNT_RET        = 5'h0D;
  localparam logic [4:0] CNT_MISPREDICT = 5'h0E;
  localparam logic [4:0] CNT_SB_FULL    = 5'h0F;
  localparam logic [4:0] CNT_IF_EMPTY   = 5'h10;

  // Counters occupy a dense window starting at ADDR_FIRST.
  localparam int ADDR_FIRST = 3;
  localparam int NUM_CNT    = 14;

  // Storage index for a counter address inside the dense window.
  function automatic int cnt_idx(input logic [4:0] addr);
    return int'(addr) - ADDR_FIRST;
  endfunction

  // x1 (ra) and x5 (t0) are the link registers of the calling convention.
  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic is_call(input commit_entry_t e);
    return (e.fu == CTRL_FLOW) && ((e.op == JAL) || (e.op == JALR)) && is_link_reg(e.rd);
  endfunction

  function automatic logic is_ret(input commit_entry_t e);
    return (e.fu == CTRL_FLOW) && (e.op == JALR) && is_link_reg(e.rs1) && (e.rd == 5'd0);
  endfunction

endpackage

// File: rtl/perf_commit_decode.sv
// Per-port commit classifier plus popcount: reports how many acked ports
// committed a load, store, call or return this cycle.
module perf_commit_decode
  import perf_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 4,
  parameter int CW              = 3
) (
  input  commit_entry_t              commit_instr_i [NR_COMMIT_PORTS],
  input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
  output logic [CW-1:0]              load_cnt,
  output logic [CW-1:0]              store_cnt,
  output logic [CW-1:0]              call_cnt,
  output logic [CW-1:0]              ret_cnt
);

  logic [NR_COMMIT_PORTS-1:0] load_hit;
  logic [NR_COMMIT_PORTS-1:0] store_hit;
  logic [NR_COMMIT_PORTS-1:0] call_hit;
  logic [NR_COMMIT_PORTS-1:0] ret_hit;

  // Classify each port; an unacked port never contributes.
  always_comb begin
    load_hit  = '0;
    store_hit = '0;
    call_hit  = '0;
    ret_hit   = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      load_hit[p]  = commit_ack_i[p] && (commit_instr_i[p].fu == LOAD);
      store_hit[p] = commit_ack_i[p] && (commit_instr_i[p].fu == STORE);
      call_hit[p]  = commit_ack_i[p] && is_call(commit_instr_i[p]);
      ret_hit[p]   = commit_ack_i[p] && is_ret(commit_instr_i[p]);
    end
  end

  // Population count of each hit vector.
  always_comb begin
    load_cnt  = '0;
    store_cnt = '0;
    call_cnt  = '0;
    ret_cnt   = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      load_cnt  = load_cnt  + CW'(load_hit[p]);
      store_cnt = store_cnt + CW'(store_hit[p]);
      call_cnt  = call_cnt  + CW'(call_hit[p]);
      ret_cnt   = ret_cnt   + CW'(ret_hit[p]);
    end
  end

endmodule

// File: rtl/hpm_perf_counters.sv
// Hardware performance-monitor counter bank. Fourteen wrapping counters
// at addresses 0x03..0x10, read combinationally and overwritten by the
// CSR unit.
//
// Write interface: a write is a single-cycle strobe with no handshake.
// When we_i is high at a rising clk_i edge and addr_i names a counter,
// that counter takes data_i and its own increment for that cycle is
// dropped; every other counter keeps counting. Unmapped writes are ignored.
module hpm_perf_counters
  import perf_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       debug_mode_i,
  input  logic [4:0]                 addr_i,
  input  logic                       we_i,
  input  logic [CNT_WIDTH-1:0]       data_i,
  output logic [CNT_WIDTH-1:0]       data_o,
  input  commit_entry_t              commit_instr_i [NR_COMMIT_PORTS],
  input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
  input  logic                       l1_icache_miss_i,
  input  logic                       l1_dcache_miss_i,
  input  logic                       itlb_miss_i,
  input  logic                       dtlb_miss_i,
  input  logic                       sb_full_i,
  input  logic                       if_empty_i,
  input  exception_t                 ex_i,
  input  logic                       eret_i,
  input  bp_resolve_t                resolved_branch_i
);

  localparam int CW = $clog2(NR_COMMIT_PORTS + 1);

  logic [CW-1:0]        load_cnt;
  logic [CW-1:0]        store_cnt;
  logic [CW-1:0]        call_cnt;
  logic [CW-1:0]        ret_cnt;

  logic [CNT_WIDTH-1:0] cnt_q   [NUM_CNT];
  logic [CNT_WIDTH-1:0] inc     [NUM_CNT];
  logic [NUM_CNT-1:0]   wr_hit;

  // Exception cause/value are not counted, only the valid strobe.
  logic unused_ex;
  assign unused_ex = ^{ex_i.cause, ex_i.tval};

  perf_commit_decode #(
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .CW              (CW)
  ) u_commit_decode (
    .commit_instr_i (commit_instr_i),
    .commit_ack_i   (commit_ack_i),
    .load_cnt       (load_cnt),
    .store_cnt      (store_cnt),
    .call_cnt       (call_cnt),
    .ret_cnt        (ret_cnt)
  );

  // Per-counter increment amount for this cycle.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) inc[i] = '0;
    inc[cnt_idx(CNT_L1I_MISS)]   = CNT_WIDTH'(l1_icache_miss_i);
    inc[cnt_idx(CNT_L1D_MISS)]   = CNT_WIDTH'(l1_dcache_miss_i);
    inc[cnt_idx(CNT_ITLB_MISS)]  = CNT_WIDTH'(itlb_miss_i);
    inc[cnt_idx(CNT_DTLB_MISS)]  = CNT_WIDTH'(dtlb_miss_i);
    inc[cnt_idx(CNT_LOAD)]       = CNT_WIDTH'(load_cnt);
    inc[cnt_idx(CNT_STORE)]      = CNT_WIDTH'(store_cnt);
    inc[cnt_idx(CNT_EXCEPTION)]  = CNT_WIDTH'(ex_i.valid);
    inc[cnt_idx(CNT_ERET)]       = CNT_WIDTH'(eret_i);
    inc[cnt_idx(CNT_BRANCH)]     = CNT_WIDTH'(resolved_branch_i.valid);
    inc[cnt_idx(CNT_CALL)]       = CNT_WIDTH'(call_cnt);
    inc[cnt_idx(CNT_RET)]        = CNT_WIDTH'(ret_cnt);
    inc[cnt_idx(CNT_MISPREDICT)] = CNT_WIDTH'(resolved_branch_i.valid && resolved_branch_i.is_mispredict);
    inc[cnt_idx(CNT_SB_FULL)]    = CNT_WIDTH'(sb_full_i);
    inc[cnt_idx(CNT_IF_EMPTY)]   = CNT_WIDTH'(if_empty_i);
  end

  // Decode which counter (if any) the CSR write targets.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      wr_hit[i] = we_i && (addr_i == 5'(ADDR_FIRST + i));
    end
  end

  // Counter update: write beats increment; debug mode freezes increments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (wr_hit[i]) begin
          cnt_q[i] <= data_i;
        end else if (!debug_mode_i) begin
          cnt_q[i] <= cnt_q[i] + inc[i];
        end
      end
    end
  end

  // Combinational read; unmapped addresses return zero.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (addr_i == 5'(ADDR_FIRST + i)) data_o = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_hpm_perf_counters.sv
// Directed bench for the performance counter bank. Expected counter values
// live in exp_cnt, indexed by address, and are updated by hand per step.
`timescale 1ns/1ps
module tb_hpm_perf_counters;
  import perf_pkg::*;

  localparam int NP = 4;
  localparam int W  = 32;

  // Clock and reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic                debug_mode_i;
  logic [4:0]          addr_i;
  logic                we_i;
  logic [W-1:0]        data_i;
  logic [W-1:0]        data_o;
  commit_entry_t       commit_instr_i [NP];
  logic [NP-1:0]       commit_ack_i;
  logic                l1_icache_miss_i;
  logic                l1_dcache_miss_i;
  logic                itlb_miss_i;
  logic                dtlb_miss_i;
  logic                sb_full_i;
  logic                if_empty_i;
  exception_t          ex_i;
  logic                eret_i;
  bp_resolve_t         resolved_branch_i;

  hpm_perf_counters #(.NR_COMMIT_PORTS(NP), .CNT_WIDTH(W)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .debug_mode_i      (debug_mode_i),
    .addr_i            (addr_i),
    .we_i              (we_i),
    .data_i            (data_i),
    .data_o            (data_o),
    .commit_instr_i    (commit_instr_i),
    .commit_ack_i      (commit_ack_i),
    .l1_icache_miss_i  (l1_icache_miss_i),
    .l1_dcache_miss_i  (l1_dcache_miss_i),
    .itlb_miss_i       (itlb_miss_i),
    .dtlb_miss_i       (dtlb_miss_i),
    .sb_full_i         (sb_full_i),
    .if_empty_i        (if_empty_i),
    .ex_i              (ex_i),
    .eret_i            (eret_i),
    .resolved_branch_i (resolved_branch_i)
  );

  // Scoreboard state
  int tests  = 0;
  int failed = 0;
  logic [W-1:0] exp_cnt [32];

  // Driver tasks
  task automatic cycle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_port(input int p, input fu_t fu, input op_t op,
                          input logic [4:0] rs1, input logic [4:0] rd, input logic ack);
    commit_instr_i[p] = '{fu: fu, op: op, rs1: rs1, rd: rd};
    commit_ack_i[p]   = ack;
  endtask

  task automatic all_events(input logic v);
    l1_icache_miss_i  = v;
    l1_dcache_miss_i  = v;
    itlb_miss_i       = v;
    dtlb_miss_i       = v;
    sb_full_i         = v;
    if_empty_i        = v;
    ex_i              = '{cause: 32'h5, tval: 32'h100, valid: v};
    eret_i            = v;
    resolved_branch_i = '{valid: v, is_mispredict: v};
    for (int p = 0; p < NP; p++) set_port(p, v ? LOAD : NONE, ADD, 5'd0, 5'd0, v);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [4:0] a);
    addr_i = a;
    #1;
    check(tag, data_o, exp_cnt[a]);
  endtask

  // Reads every address; callers keep events low and we_i off meanwhile.
  task automatic check_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      read_check($sformatf("%s_a%02h", tag, a), 5'(a));
    end
  endtask

  initial begin
    for (int a = 0; a < 32; a++) exp_cnt[a] = '0;
    debug_mode_i = 1'b0;
    addr_i       = 5'd0;
    we_i         = 1'b0;
    data_i       = '0;
    all_events(1'b1);

    // Reset with every event high: everything reads 0.
    cycle(2);
    check_all("rst");
    all_events(1'b0);
    cycle(1);
    rst_i = 1'b0;
    cycle(1);
    check_all("idle");

    // Single-bit events.
    l1_icache_miss_i = 1'b1;
    cycle(3);
    l1_icache_miss_i = 1'b0;
    exp_cnt[5'h03] = 3;
    read_check("l1i_3", 5'h03);

    sb_full_i = 1'b1;
    cycle(1);
    sb_full_i = 1'b0;
    exp_cnt[5'h0F] = 1;
    read_check("sb_full_1", 5'h0F);

    // Loads on ports 0,1 acked; port 2 load not acked; port 3 store acked.
    set_port(0, LOAD, LW, 5'd2, 5'd3, 1'b1);
    set_port(1, LOAD, LW, 5'd2, 5'd4, 1'b1);
    set_port(2, LOAD, LW, 5'd2, 5'd6, 1'b0);
    set_port(3, STORE, SW, 5'd2, 5'd0, 1'b1);
    cycle(1);
    all_events(1'b0);
    exp_cnt[5'h07] = 2;
    exp_cnt[5'h08] = 1;
    read_check("load_2", 5'h07);
    read_check("store_1", 5'h08);

    // Port 3 JALR rd=x1 is a call.
    set_port(3, CTRL_FLOW, JALR, 5'd2, 5'd1, 1'b1);
    cycle(1);
    all_events(1'b0);
    exp_cnt[5'h0C] = 1;
    read_check("call_1", 5'h0C);
    read_check("ret_0", 5'h0D);

    // JALR rs1=x1 rd=x0 is a return; JAL rd=x5 is a call; unacked return ignored.
    set_port(0, CTRL_FLOW, JALR, 5'd1, 5'd0, 1'b1);
    set_port(1, CTRL_FLOW, JAL,  5'd0, 5'd5, 1'b1);
    set_port(2, CTRL_FLOW, JALR, 5'd5, 5'd0, 1'b0);
    set_port(3, ALU, ADD, 5'd1, 5'd1, 1'b1);
    cycle(1);
    all_events(1'b0);
    exp_cnt[5'h0D] = 1;
    exp_cnt[5'h0C] = 2;
    read_check("ret_1", 5'h0D);
    read_check("call_2", 5'h0C);

    // Remaining strobes for one cycle, correct prediction.
    l1_dcache_miss_i  = 1'b1;
    itlb_miss_i       = 1'b1;
    dtlb_miss_i       = 1'b1;
    if_empty_i        = 1'b1;
    eret_i            = 1'b1;
    ex_i              = '{cause: 32'h2, tval: 32'h0, valid: 1'b1};
    resolved_branch_i = '{valid: 1'b1, is_mispredict: 1'b0};
    cycle(1);
    all_events(1'b0);
    // Mispredicted branch, plus an exception record without valid.
    resolved_branch_i = '{valid: 1'b1, is_mispredict: 1'b1};
    ex_i              = '{cause: 32'hD, tval: 32'h44, valid: 1'b0};
    cycle(1);
    all_events(1'b0);
    // Mispredict flag without valid does not count anywhere.
    resolved_branch_i = '{valid: 1'b0, is_mispredict: 1'b1};
    cycle(1);
    all_events(1'b0);
    exp_cnt[5'h04] = 1;
    exp_cnt[5'h05] = 1;
    exp_cnt[5'h06] = 1;
    exp_cnt[5'h09] = 1;
    exp_cnt[5'h0A] = 1;
    exp_cnt[5'h0B] = 2;
    exp_cnt[5'h0E] = 1;
    exp_cnt[5'h10] = 1;
    check_all("events");

    // Debug freeze: everything high for 5 cycles, nothing moves.
    debug_mode_i = 1'b1;
    all_events(1'b1);
    cycle(5);
    all_events(1'b0);
    // Writes still land while frozen.
    we_i   = 1'b1;
    addr_i = 5'h05;
    data_i = 32'h0000_1234;
    cycle(1);
    we_i         = 1'b0;
    debug_mode_i = 1'b0;
    exp_cnt[5'h05] = 32'h0000_1234;
    check_all("debug");

    // Write wins over same-cycle event; other counter still counts.
    we_i             = 1'b1;
    addr_i           = 5'h04;
    data_i           = 32'hFFFF_FFFF;
    l1_dcache_miss_i = 1'b1;
    l1_icache_miss_i = 1'b1;
    cycle(1);
    we_i             = 1'b0;
    l1_icache_miss_i = 1'b0;
    exp_cnt[5'h04] = 32'hFFFF_FFFF;
    exp_cnt[5'h03] = 4;
    read_check("wr_ffff", 5'h04);
    cycle(1);
    l1_dcache_miss_i = 1'b0;
    exp_cnt[5'h04] = 32'h0;
    read_check("wrap_0", 5'h04);
    read_check("l1i_4", 5'h03);

    // Unmapped writes are ignored.
    we_i   = 1'b1;
    addr_i = 5'h11;
    data_i = 32'h0000_0055;
    cycle(1);
    addr_i = 5'h02;
    cycle(1);
    we_i = 1'b0;
    check_all("unmapped");

    // Async reset between edges, with a write and event pending.
    l1_icache_miss_i = 1'b1;
    cycle(2);
    exp_cnt[5'h03] = 6;
    addr_i = 5'h03;
    #1;
    check(("pre_rst"), data_o, exp_cnt[5'h03]);
    we_i   = 1'b1;
    data_i = 32'h0000_AAAA;
    #1;
    rst_i = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) exp_cnt[a] = '0;
    check("async_rst", data_o, 32'h0);
    we_i             = 1'b0;
    l1_icache_miss_i = 1'b0;
    cycle(1);
    rst_i = 1'b0;
    cycle(1);
    check_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
